// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 32-step multiply/divide sequencer for the execute stage
// Ports: clk, rst (async, active-low); start/md_op/src0/src1 accept one M-extension op in IDLE;
//        flush aborts; busy = not IDLE; stall holds IF/ID/EX (combinational);
//        done pulses with result, which holds until overwritten by the next completed op.
// Option: define MULDIV_EARLY_OUT_EN to skip CALC when an operand is zero.
module muldiv_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] src0,
   input  logic [XLEN-1:0] src1,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t      state;
   logic [2:0]  op;
   logic [31:0] orig, a, b;
   logic        neg_a, neg_b, dz;
   logic [63:0] acc;
   logic [4:0]  cnt;
   logic        sa_in, sb_in, na_in, nb_in, skip, sgn, ge;
   logic [31:0] mag0, mag1, quo, rem, fix_res;
   logic [32:0] psum, rsh, dif;
   logic [63:0] mul_next, div_next, prod;
   always_comb begin
      sa_in = (md_op == 3'b001) | (md_op == 3'b010) | (md_op == 3'b100) | (md_op == 3'b110);
      sb_in = (md_op == 3'b001) | (md_op == 3'b100) | (md_op == 3'b110);
      na_in = sa_in & src0[31];
      nb_in = sb_in & src1[31];
      mag0  = na_in ? -src0 : src0;
      mag1  = nb_in ? -src1 : src1;
`ifdef MULDIV_EARLY_OUT_EN
      skip  = (src1 == '0) | (src0 == '0);
`else
      skip  = 1'b0;
`endif
      // multiply: add multiplicand into upper half, then shift {carry, acc} right
      psum     = {1'b0, acc[63:32]} + (b[0] ? {1'b0, a} : 33'd0);
      mul_next = {psum, acc[31:1]};
      // divide: dividend bits enter rem from a's MSB; rem is 33 bits wide before the trial subtract
      rsh      = {acc[63:32], a[31]};
      dif      = rsh - {1'b0, b};
      ge       = rsh >= {1'b0, b};
      div_next = {ge ? dif[31:0] : rsh[31:0], acc[30:0], ge};
      sgn      = neg_a ^ neg_b;
      prod     = sgn ? -acc : acc;
      quo      = dz ? 32'hFFFF_FFFF : (sgn ? -acc[31:0] : acc[31:0]);
      rem      = dz ? orig : (neg_a ? -acc[63:32] : acc[63:32]);
      fix_res  = !op[2] ? ((op[1:0] == 2'b00) ? prod[31:0] : prod[63:32]) : (op[1] ? rem : quo);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         op     <= '0;
         orig   <= '0;
         a      <= '0;
         b      <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         dz     <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         result <= '0;
      end else if (flush) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op    <= md_op;
                  orig  <= src0;
                  a     <= mag0;
                  b     <= mag1;
                  neg_a <= na_in;
                  neg_b <= nb_in;
                  dz    <= src1 == '0;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= skip ? FIX : CALC;
               end
            end
            CALC: begin
               acc <= op[2] ? div_next : mul_next;
               a   <= op[2] ? {a[30:0], 1'b0} : a;
               b   <= op[2] ? b : {1'b0, b[31:1]};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= FIX;
            end
            FIX: begin
               result <= fix_res;
               done   <= 1'b1;
               state  <= DONE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
   assign busy  = state != IDLE;
   assign stall = ((state == IDLE) & start & ~flush) | (state == CALC) | (state == FIX);
endmodule
